ax_adder_error_monitor: RTL
===========================

# ax_adder_error_monitor

Downstream consumer of the 16-bit approximate prefix adders. It takes each adder's operands and its 17-bit result (final carry-out concatenated with sum) and recomputes the exact sum internally. Over a fixed window of accepted samples it accumulates error statistics: error count, error-distance sum, maximum error distance and mean error distance (MED). Results are held for readout under a done/ack handshake, so the same monitor can characterise any adder variant in the family.

## Interface
Parameters:
- WIDTH, 16, operand width; the result width is WIDTH+1.
- WINDOW_LOG2, 10, window length is 2^WINDOW_LOG2 accepted samples; legal range 1..16.
- ACC_W, WIDTH+1+WINDOW_LOG2, width of the error-distance sum; it cannot overflow.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that opens a window; honoured only in IDLE.
- in_valid  in  1  sample present on op_a/op_b/cin/approx_sum.
- in_ready  out  1  monitor accepts a sample this cycle.
- op_a  in  WIDTH  adder operand A.
- op_b  in  WIDTH  adder operand B.
- cin  in  1  adder carry-in.
- approx_sum  in  WIDTH+1  adder result, {carry_out[WIDTH], sum[WIDTH:1]}.
- done  out  1  results valid and held.
- ack  in  1  releases the results; honoured only in DONE.
- busy  out  1  high in ACCUM or DRAIN.
- err_count  out  WINDOW_LOG2+1  number of samples with nonzero error distance.
- ed_sum  out  ACC_W  sum of error distances.
- ed_max  out  WIDTH+1  largest error distance in the window.
- med  out  WIDTH+1  ed_sum >> WINDOW_LOG2, truncated (floor).

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0, done=0.
  - On start: go to ACCUM; clear the accepted counter, err_count, ed_sum and ed_max.
- ACCUM:
  - in_ready=1 while the accepted count is below 2^WINDOW_LOG2.
  - A sample is accepted when in_valid & in_ready.
  - When the final sample is accepted: in_ready=0 from the next cycle, go to DRAIN.
- DRAIN:
  - in_ready=0; wait until the pipeline is empty, then go to DONE.
- DONE:
  - done=1; all outputs are frozen.
  - On ack: go to IDLE, done=0. Outputs keep their values until the next start clears them.
- Pipeline:
  - S1 registers exact = op_a + op_b + cin (WIDTH+1 bits, unsigned) and approx_sum.
  - S2 registers ed = |exact - approx_sum| (WIDTH+1 bits, unsigned, no wrap) and nz = (ed != 0).
  - S3 performs err_count += nz, ed_sum += ed, ed_max = max(ed_max, ed).
  - Each stage has a valid bit. Bubbles (in_valid=0) are never accumulated.
- start outside IDLE and ack outside DONE are ignored.
- in_valid while in_ready=0 is ignored: no count, no data capture.
- Reset in any state:
  - State=IDLE, pipeline valids cleared.
  - All outputs are 0: in_ready, busy, done, err_count, ed_sum, ed_max, med.
  - A partial window is discarded.

## Timing
- start sampled high at edge t: state=ACCUM and in_ready=1 from edge t (visible in cycle t+1).
- Sample accepted at edge k: S1 valid after k, S2 valid after k+1, accumulators updated at k+2.
- Final sample accepted at edge k:
  - in_ready=0 after k.
  - Accumulators final at k+2.
  - done=1 after edge k+2, with all result outputs valid in the same cycle.
- Throughput is one sample per cycle with in_valid held high. A full window takes 2^WINDOW_LOG2 cycles of acceptance plus 2 cycles of drain.
- ack sampled at edge d: done=0 after d. A start at edge d+1 is honoured.
- med is combinational from ed_sum, so it is valid whenever ed_sum is.

## Test plan
Directed scenarios, using WINDOW_LOG2=2 (window of 4) unless noted:
- Reset, then idle cycles with in_valid=1 → in_ready=0, done=0, every result 0.
- start; 4 samples with approx_sum equal to the exact sum (for example 0x1234+0x0101+1 → 0x01336) → done 2 cycles after the 4th accept; err_count=0, ed_sum=0, ed_max=0, med=0.
- start; samples:
  - op_a=0xFFFF, op_b=0x0001, cin=0, approx_sum=0x00000 (exact 0x10000, ed 65536);
  - op_a=1, op_b=1, cin=1, approx_sum=0x00007 (approx above exact, ed 4);
  - two exact samples.
  - Expect err_count=2, ed_sum=65540, ed_max=65536, med=16385.
- Bubbles and backpressure: in_valid toggles 1,0,1,0,... then is held high for 3 extra cycles after the 4th accept → only 4 samples counted, in_ready=0 after the 4th accept, the extra samples are ignored, done timing is still k+2.
- Control handshake:
  - start pulsed in DONE → ignored, outputs unchanged.
  - ack → IDLE with done=0 and results still visible.
  - A new start → results cleared to 0 within 1 cycle.
- rst asserted after 2 accepts mid-window → all outputs 0, state IDLE. A subsequent start plus 4 zero-error samples → err_count=0 (no carry-over from the discarded window).

Source files
------------

// File: rtl/ax_adder_error_monitor.sv
// Error-statistics monitor for approximate adders: recomputes the exact sum and accumulates error metrics over a fixed window.
// Latency: 3-stage pipeline (S1 exact sum, S2 error distance, S3 accumulate); done rises 2 cycles after the final accept.
// Backpressure: in_ready is high only in ACCUM until the window is full; results are held in DONE until ack.
module ax_adder_error_monitor #(
  parameter int WIDTH       = 16,
  parameter int WINDOW_LOG2 = 10,
  parameter int ACC_W       = WIDTH + 1 + WINDOW_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       op_a,
  input  logic [WIDTH-1:0]       op_b,
  input  logic                   cin,
  input  logic [WIDTH:0]         approx_sum,
  output logic                   done,
  input  logic                   ack,
  output logic                   busy,
  output logic [WINDOW_LOG2:0]   err_count,
  output logic [ACC_W-1:0]       ed_sum,
  output logic [WIDTH:0]         ed_max,
  output logic [WIDTH:0]         med
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic [WINDOW_LOG2:0] WIN_LEN  = {1'b1, {WINDOW_LOG2{1'b0}}};
  localparam logic [WINDOW_LOG2:0] WIN_LAST = WIN_LEN - 1'b1;

  state_t                 state, state_nxt;
  logic [WINDOW_LOG2:0]   acc_cnt;
  logic                   accept;
  logic                   last_accept;
  logic                   clear;

  logic                   s1_vld;
  logic [WIDTH:0]         s1_exact;
  logic [WIDTH:0]         s1_approx;
  logic                   s2_vld;
  logic [WIDTH:0]         s2_ed;
  logic                   s2_nz;
  logic [WIDTH:0]         ed_c;

  // Accept only while collecting and the window still has room.
  assign in_ready    = (state == ACCUM) && (acc_cnt < WIN_LEN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == WIN_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs; DRAIN exits once only S2 still holds data,
  // since S2 is consumed by the accumulators on the same edge.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          clear     = 1'b1;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (last_accept) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_vld) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accepted-sample counter for the current window.
  always_ff @(posedge clk) begin
    if (rst || clear) acc_cnt <= '0;
    else if (accept)  acc_cnt <= acc_cnt + 1'b1;
  end

  // S1: exact reference sum alongside the adder's result; data captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_exact  <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        s1_approx <= approx_sum;
      end
    end
  end

  // Absolute error distance, ordered subtraction so it never wraps.
  always_comb begin
    ed_c = '0;
    if (s1_exact >= s1_approx) ed_c = s1_exact - s1_approx;
    else                       ed_c = s1_approx - s1_exact;
  end

  // S2: error distance and nonzero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_ed  <= '0;
      s2_nz  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_ed <= ed_c;
        s2_nz <= (ed_c != '0);
      end
    end
  end

  // S3: accumulate statistics; nothing arrives in DONE, so results stay frozen there.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count <= '0;
      ed_sum    <= '0;
      ed_max    <= '0;
    end else if (s2_vld) begin
      err_count <= err_count + {{WINDOW_LOG2{1'b0}}, s2_nz};
      ed_sum    <= ed_sum + ACC_W'(s2_ed);
      if (s2_ed > ed_max) ed_max <= s2_ed;
    end
  end

  // Mean error distance: window length is a power of two, so a shift gives the floor.
  assign med = ed_sum[WINDOW_LOG2 +: WIDTH+1];

endmodule
